gc_response_rx: RTL and testbench
=================================

// Module: gc_response_rx
// PURPOSE
//  Receives and decodes the controller's reply on the single-wire GameCube data line.
//  Sits directly downstream of the query sender. Armed when the sender releases the line
//  (its send output falls). Measures each bit's low time at 100 MHz, shifts in NBITS
//  response bits, checks the stop bit, then presents the word to the button/stick decode.
// PARAMETERS
//  NBITS     64     response bits expected before the stop bit
//  THRESH    200    low-time cycles; low < THRESH decodes 1 (~1us), else 0 (~3us)
//  LOW_MAX   450    low-time cycles at which the line is declared stuck (frame error)
//  RESP_TO   10000  cycles allowed from arm to first falling edge
//  BIT_TO    600    cycles allowed from a rising edge to the next falling edge
// PORTS
//  clk100mhz   in   1      100 MHz system clock
//  reset       in   1      asynchronous, active-high reset
//  data_in     in   1      raw GC line (async; external pull-up, so z reads as 1)
//  arm         in   1      1-cycle pulse: query transmission finished, start listening
//  busy        out  1      high from accepted arm until DONE or error
//  resp_data   out  NBITS  last good response; first received bit at [NBITS-1]
//  resp_valid  out  1      1-cycle pulse when resp_data updates
//  timeout_err out  1      1-cycle pulse: RESP_TO or BIT_TO expired
//  frame_err   out  1      1-cycle pulse: low >= LOW_MAX, or long (0) stop bit
// BEHAVIOUR
//  - One clock, clk100mhz. reset is asynchronous, active-high, and wins over everything.
//  - Reset clears all outputs, shift register, counters and sync flops to 0; state = IDLE.
//  - data_in goes through a 2-flop synchronizer. Edges are detected on the synced value.
//  - FSM states: IDLE, WAIT_EDGE, MEAS_LOW, DONE.
//  - IDLE: arm moves to WAIT_EDGE and clears bit_cnt, the timer and the shift register.
//    arm in any other state is ignored.
//  - WAIT_EDGE: the timer counts.
//    - A falling edge moves to MEAS_LOW with low_cnt=0.
//    - Timer >= RESP_TO (bit_cnt==0) or >= BIT_TO (bit_cnt>0): pulse timeout_err, go IDLE.
//  - MEAS_LOW: low_cnt counts; it is 16-bit and saturating.
//    - low_cnt reaches LOW_MAX: pulse frame_err, go IDLE.
//    - Rising edge with bit_cnt<NBITS: shift left, LSB = (low_cnt<THRESH), bit_cnt++.
//      Then go to WAIT_EDGE with the timer cleared.
//    - Rising edge with bit_cnt==NBITS (stop bit): if low_cnt<THRESH go DONE, else pulse
//      frame_err and go IDLE.
//  - DONE lasts one cycle.
//    - Copies the shift register to resp_data and pulses resp_valid; then goes to IDLE.
//    - Latency: resp_valid is high 3 cycles after the raw stop-bit rise (2 sync + 1).
//  - resp_data holds its value until the next successful frame. Errors never modify it.
//  - busy is 1 in WAIT_EDGE, MEAS_LOW and DONE.
//  - A falling edge seen in IDLE is ignored (sender echo or bus noise).
//  - Boundary: low_cnt==THRESH-1 decodes 1; low_cnt==THRESH decodes 0.
//  - A reset mid-frame discards the partial frame; no pulse is emitted.
// STRUCTURE
//  - Shared include gc_defs.vh: GC_THRESH, GC_LOW_MAX, GC_RESP_TO, GC_BIT_TO,
//    GC_RESP_BITS, FSM state encodings. These are shared with the query sender and
//    the stick/button unpacker.
//  - Sub-module gc_line_sync: 2-flop synchronizer plus rise/fall strobes, with the same
//    reset.
//  - Top level: FSM, counters, shift register and output register.
// TESTING
//  1. Reset held, toggle data_in -> all outputs 0, busy 0.
//     Release reset: outputs still 0 and no pulses.
//  2. arm, then 64 bits of 64'hA5F0_0FFF_8080_1234 (1=100 low/300 high, 0=300/100) plus a
//     100-cycle stop bit -> one resp_valid, resp_data matches, busy falls with it.
//  3. arm, line held high for 10000 cycles -> timeout_err pulse at cycle RESP_TO;
//     no resp_valid; a second arm then decodes a full frame correctly.
//  4. Frame cut after 40 bits -> timeout_err 600 cycles after the last rise.
//     Then: a low held 500 cycles -> frame_err at low_cnt=450. Both: resp_data unchanged.
//  5. Lows of 199 and 200 cycles -> bits 1 and 0. A 300-cycle stop bit -> frame_err,
//     no resp_valid.
//  6. Reset asserted at bit 30 -> immediate idle, no pulses.
//     A following arm and full frame -> correct resp_data.

Source files
------------

// File: rtl/gc_response_rx_pkg.sv
// Shared GameCube line timing constants and receiver FSM encodings, also used by
// the query sender and the stick/button unpacker.
package gc_response_rx_pkg;

  localparam int unsigned GC_RESP_BITS = 64;
  localparam int unsigned GC_THRESH    = 200;
  localparam int unsigned GC_LOW_MAX   = 450;
  localparam int unsigned GC_RESP_TO   = 10000;
  localparam int unsigned GC_BIT_TO    = 600;

  localparam int unsigned GC_CNT_W = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_MEAS_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  function automatic logic [GC_CNT_W-1:0] gc_sat_inc(input logic [GC_CNT_W-1:0] v);
    return (v == '1) ? v : v + GC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gc_response_rx_line_sync.sv
// Two-flop synchronizer for the raw GC data line with single-cycle rise/fall strobes.
module gc_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/gc_response_rx.sv
// GameCube controller reply receiver: measures each bit's low time, shifts in the
// response bits, checks the stop bit and publishes the word.
module gc_response_rx
  import gc_response_rx_pkg::*;
#(
  parameter int unsigned NBITS   = GC_RESP_BITS,
  parameter int unsigned THRESH  = GC_THRESH,
  parameter int unsigned LOW_MAX = GC_LOW_MAX,
  parameter int unsigned RESP_TO = GC_RESP_TO,
  parameter int unsigned BIT_TO  = GC_BIT_TO
) (
  input  logic             clk100mhz,
  input  logic             reset,
  input  logic             data_in,
  input  logic             arm,
  output logic             busy,
  output logic [NBITS-1:0] resp_data,
  output logic             resp_valid,
  output logic             timeout_err,
  output logic             frame_err
);

  localparam int unsigned BW = $clog2(NBITS + 1);

  localparam logic [BW-1:0]       NBITS_C   = BW'(NBITS);
  localparam logic [BW-1:0]       BIT_ONE   = BW'(1);
  localparam logic [GC_CNT_W-1:0] THRESH_C  = GC_CNT_W'(THRESH);
  localparam logic [GC_CNT_W-1:0] LOW_MAX_C = GC_CNT_W'(LOW_MAX);
  localparam logic [GC_CNT_W-1:0] RESP_TO_C = GC_CNT_W'(RESP_TO);
  localparam logic [GC_CNT_W-1:0] BIT_TO_C  = GC_CNT_W'(BIT_TO);

  logic rise;
  logic fall;

  logic [1:0]          state_q,      state_d;
  logic [BW-1:0]       bit_cnt_q,    bit_cnt_d;
  logic [GC_CNT_W-1:0] timer_q,      timer_d;
  logic [GC_CNT_W-1:0] low_cnt_q,    low_cnt_d;
  logic [NBITS-1:0]    shift_q,      shift_d;
  logic [NBITS-1:0]    resp_data_q,  resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                timeout_q,    timeout_d;
  logic                frame_q,      frame_d;

  logic [GC_CNT_W-1:0] low_inc;
  logic [GC_CNT_W-1:0] timer_limit;
  logic                long_low;

  gc_line_sync u_sync (
    .clk_i  (clk100mhz),
    .rst_i  (reset),
    .line_i (data_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // low_inc counts the current cycle too, so it equals the full low length at the rise
  assign low_inc     = gc_sat_inc(low_cnt_q);
  assign long_low    = (low_inc >= THRESH_C);
  assign timer_limit = (bit_cnt_q == '0) ? RESP_TO_C : BIT_TO_C;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    timer_d      = timer_q;
    low_cnt_d    = low_cnt_q;
    shift_d      = shift_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    timeout_d    = 1'b0;
    frame_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_WAIT_EDGE;
          bit_cnt_d = '0;
          timer_d   = '0;
          shift_d   = '0;
        end
      end

      ST_WAIT_EDGE: begin
        if (fall) begin
          state_d   = ST_MEAS_LOW;
          low_cnt_d = '0;
        end else if (timer_q >= timer_limit) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = gc_sat_inc(timer_q);
        end
      end

      ST_MEAS_LOW: begin
        if (rise) begin
          if (bit_cnt_q < NBITS_C) begin
            shift_d   = {shift_q[NBITS-2:0], ~long_low};
            bit_cnt_d = bit_cnt_q + BIT_ONE;
            timer_d   = '0;
            state_d   = ST_WAIT_EDGE;
          end else if (!long_low) begin
            // word and strobe are registered on entry so they coincide with DONE
            resp_data_d  = shift_q;
            resp_valid_d = 1'b1;
            state_d      = ST_DONE;
          end else begin
            frame_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (low_inc >= LOW_MAX_C) begin
          frame_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          low_cnt_d = low_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      timer_q      <= '0;
      low_cnt_q    <= '0;
      shift_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      timer_q      <= timer_d;
      low_cnt_q    <= low_cnt_d;
      shift_q      <= shift_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      timeout_q    <= timeout_d;
      frame_q      <= frame_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign resp_data   = resp_data_q;
  assign resp_valid  = resp_valid_q;
  assign timeout_err = timeout_q;
  assign frame_err   = frame_q;

endmodule

// File: tb/tb_gc_response_rx.sv
// Directed + randomized bench for gc_response_rx with a low-time based reference model.
module tb_gc_response_rx;

  localparam int THRESH  = 200;
  localparam int LOW_MAX = 450;
  localparam int RESP_TO = 10000;
  localparam int BIT_TO  = 600;

  logic        clk100mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        data_in   = 1'b1;
  logic        arm       = 1'b0;
  logic        busy;
  logic [63:0] resp_data;
  logic        resp_valid;
  logic        timeout_err;
  logic        frame_err;

  always #5 clk100mhz = ~clk100mhz;

  gc_response_rx dut (
    .clk100mhz   (clk100mhz),
    .reset       (reset),
    .data_in     (data_in),
    .arm         (arm),
    .busy        (busy),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .timeout_err (timeout_err),
    .frame_err   (frame_err)
  );

  int cyc = 0;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  int          n_valid = 0, n_tout = 0, n_ferr = 0;
  int          valid_cyc = 0, tout_cyc = 0, ferr_cyc = 0;
  logic [63:0] valid_data = '0;
  logic        valid_busy = 1'b0;

  always @(negedge clk100mhz) begin
    if (!reset) begin
      if (resp_valid) begin
        n_valid++;
        valid_cyc  = cyc;
        valid_data = resp_data;
        valid_busy = busy;
      end
      if (timeout_err) begin
        n_tout++;
        tout_cyc = cyc;
      end
      if (frame_err) begin
        n_ferr++;
        ferr_cyc = cyc;
      end
    end
  end

  int compared = 0;
  int mismatched = 0;

  // entries 0..63 are data bits, entry 64 is the stop bit
  int lows[65];
  int highs[65];
  int last_rise = 0;
  int arm_cyc = 0;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100mhz);
      #1;
    end
  endtask

  task automatic pulse_arm();
    arm     = 1'b1;
    arm_cyc = cyc;
    step(1);
    arm = 1'b0;
  endtask

  task automatic fill_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) begin
      lows[i]  = w[63-i] ? 100 : 300;
      highs[i] = w[63-i] ? 300 : 100;
    end
    lows[64]  = 100;
    highs[64] = 100;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      lows[i]  = ($urandom % 2 == 1) ? int'($urandom_range(20, 100)) : int'($urandom_range(210, 240));
      highs[i] = int'($urandom_range(10, 20));
    end
    lows[64]  = int'($urandom_range(20, 100));
    highs[64] = 20;
  endtask

  task automatic drive_entries(input int n);
    for (int i = 0; i < n; i++) begin
      data_in = 1'b0;
      step(lows[i]);
      data_in   = 1'b1;
      last_rise = cyc;
      step(highs[i]);
    end
  endtask

  // Reference decode: a bit is 1 when its low lasted fewer than THRESH cycles.
  function automatic logic [63:0] model_word();
    logic [63:0] w = '0;
    for (int i = 0; i < 64; i++) w = {w[62:0], (lows[i] < THRESH) ? 1'b1 : 1'b0};
    return w;
  endfunction

  function automatic logic in_win(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  int          v0, t0, f0;
  logic [63:0] held;

  initial begin
    // 1: reset behaviour
    for (int i = 0; i < 10; i++) begin
      data_in = ~data_in;
      step(1);
    end
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_tout", 64'(timeout_err), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_data", resp_data, 64'd0);
    data_in = 1'b1;
    reset   = 1'b0;
    step(20);
    check("post_rst_pulses", 64'(n_valid + n_tout + n_ferr), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // 2: fixed-pattern frame
    v0 = n_valid; t0 = n_tout; f0 = n_ferr;
    fill_word(64'hA5F0_0FFF_8080_1234);
    pulse_arm();
    check("t2_busy_armed", 64'(busy), 64'd1);
    drive_entries(65);
    check("t2_valid_cnt", 64'(n_valid), 64'(v0 + 1));
    check("t2_data", valid_data, 64'hA5F0_0FFF_8080_1234);
    check("t2_latency", 64'(valid_cyc - last_rise), 64'd3);
    check("t2_busy_at_valid", 64'(valid_busy), 64'd1);
    check("t2_busy_after", 64'(busy), 64'd0);
    check("t2_no_err", 64'(n_tout + n_ferr), 64'(t0 + f0));

    // 3: response timeout, then a good frame with threshold-boundary bits
    v0 = n_valid; t0 = n_tout;
    pulse_arm();
    step(RESP_TO + 50);
    check("t3_tout_cnt", 64'(n_tout), 64'(t0 + 1));
    check("t3_tout_time", 64'(in_win(tout_cyc - arm_cyc, RESP_TO, RESP_TO + 8)), 64'd1);
    check("t3_no_valid", 64'(n_valid), 64'(v0));
    check("t3_busy", 64'(busy), 64'd0);
    fill_random();
    lows[0] = THRESH - 1;
    lows[1] = THRESH;
    pulse_arm();
    drive_entries(65);
    step(10);
    check("t3_valid_cnt", 64'(n_valid), 64'(v0 + 1));
    check("t3_data", resp_data, model_word());
    check("t3_boundary_bits", 64'(resp_data[63:62]), 64'd2);

    // 4: inter-bit timeout after 40 bits, then a stuck-low line
    held = resp_data;
    t0 = n_tout; f0 = n_ferr; v0 = n_valid;
    fill_random();
    pulse_arm();
    drive_entries(40);
    step(BIT_TO + 50);
    check("t4_tout_cnt", 64'(n_tout), 64'(t0 + 1));
    check("t4_tout_time", 64'(in_win(tout_cyc - last_rise, BIT_TO, BIT_TO + 12)), 64'd1);
    check("t4_data_kept_a", resp_data, held);
    pulse_arm();
    data_in  = 1'b0;
    fall_cyc = cyc;
    step(500);
    data_in = 1'b1;
    step(20);
    check("t4_ferr_cnt", 64'(n_ferr), 64'(f0 + 1));
    check("t4_ferr_time", 64'(in_win(ferr_cyc - fall_cyc, LOW_MAX - 5, LOW_MAX + 10)), 64'd1);
    check("t4_data_kept_b", resp_data, held);
    check("t4_no_valid", 64'(n_valid), 64'(v0));
    check("t4_busy", 64'(busy), 64'd0);

    // 5: long (zero) stop bit
    f0 = n_ferr; v0 = n_valid;
    fill_random();
    lows[64] = 300;
    pulse_arm();
    drive_entries(65);
    step(10);
    check("t5_ferr_cnt", 64'(n_ferr), 64'(f0 + 1));
    check("t5_no_valid", 64'(n_valid), 64'(v0));
    check("t5_data_kept", resp_data, held);

    // 6: reset mid-frame, then a clean frame
    v0 = n_valid; t0 = n_tout; f0 = n_ferr;
    fill_random();
    pulse_arm();
    drive_entries(30);
    data_in = 1'b0;
    step(50);
    reset = 1'b1;
    #1;
    check("t6_busy_in_rst", 64'(busy), 64'd0);
    check("t6_data_in_rst", resp_data, 64'd0);
    step(5);
    data_in = 1'b1;
    reset   = 1'b0;
    step(20);
    check("t6_no_pulses", 64'(n_valid + n_tout + n_ferr), 64'(v0 + t0 + f0));
    fill_random();
    pulse_arm();
    drive_entries(65);
    step(10);
    check("t6_valid_cnt", 64'(n_valid), 64'(v0 + 1));
    check("t6_data", resp_data, model_word());
    check("t6_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
